// File: rtl/clock_ctl.sv
// Run/halt/single-step clock controller for the cpu block.
// Derives the cpu clk/iclk phase pair and sequences cpu reset.
//
// Ports:
//   clk, rst        master clock, async active-high reset
//   run_req         free-run request (rising edge)
//   halt_req        halt request (rising edge)
//   step_req        single-cycle request (rising edge)
//   brk             cpu breakpoint output
//   div[DIV_W]      phase length minus one, in master cycles
//   cpu_clk/iclk    cpu phase pair, iclk = ~cpu_clk
//   cpu_rst/crstn   cpu reset, crstn = ~cpu_rst
//   ctrlen          cpu control enable
//   running/halted  status flags
//   cycles[16]      completed cpu cycles since reset hold ended
module clock_ctl #(
  parameter int DIV_W   = 8,
  parameter int RST_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             brk,
  input  logic [DIV_W-1:0] div,
  output logic             cpu_clk,
  output logic             cpu_iclk,
  output logic             cpu_rst,
  output logic             crstn,
  output logic             ctrlen,
  output logic             running,
  output logic             halted,
  output logic [15:0]      cycles
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [1:0] {
    ST_RST,
    ST_HALT,
    ST_RUN,
    ST_STEP
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic             r_act;
  logic             w_act_n;
  logic             r_ph;
  logic             w_ph_n;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_n;
  logic [RW-1:0]    r_rcnt;
  logic [RW-1:0]    w_rcnt_n;
  logic [15:0]      r_cycles;
  logic [15:0]      w_cycles_n;
  logic             r_pend;
  logic             w_pend_n;
  logic             r_first;
  logic             w_first_n;
  logic             r_clk;
  logic             w_clk_n;

  logic             r_iclk;
  logic             r_cpu_rst;
  logic             r_crstn;
  logic             r_ctrlen;
  logic             r_running;
  logic             r_halted;

  logic             r_run_p;
  logic             r_halt_p;
  logic             r_step_p;

  logic             w_run_e;
  logic             w_halt_e;
  logic             w_step_e;
  logic             w_brk_stop;
  logic             w_in_rst_n;

  // r_act: a cpu cycle is in progress; r_ph: 0 = PH_HI, 1 = PH_LO.
  // r_cnt counts down the current phase; at zero the phase ends.
  always_comb begin
    w_state_n  = r_state;
    w_act_n    = r_act;
    w_ph_n     = r_ph;
    w_cnt_n    = r_cnt;
    w_rcnt_n   = r_rcnt;
    w_cycles_n = r_cycles;
    w_pend_n   = r_pend;
    w_first_n  = r_first;
    w_clk_n    = r_clk;

    w_run_e    = run_req  & ~r_run_p;
    w_halt_e   = halt_req & ~r_halt_p;
    w_step_e   = step_req & ~r_step_p;
    // first cycle after a run ignores brk so the cpu can
    // leave the breakpoint it stopped on
    w_brk_stop = brk & ~r_first;

    if ((r_state == ST_RUN || r_state == ST_STEP) && w_halt_e)
      w_pend_n = 1'b1;

    unique case (r_state)
      ST_HALT: begin
        w_pend_n = 1'b0;
        if (w_halt_e) begin
          w_state_n = ST_HALT;
        end else if (w_run_e) begin
          w_state_n = ST_RUN;
          w_first_n = 1'b1;
        end else if (w_step_e) begin
          w_state_n = ST_STEP;
        end
      end
      default: begin
        if (!r_act) begin
          w_act_n = 1'b1;
          w_ph_n  = 1'b0;
          w_cnt_n = div;
          w_clk_n = 1'b1;
        end else if (r_cnt != '0) begin
          w_cnt_n = r_cnt - DIV_W'(1);
        end else if (!r_ph) begin
          w_ph_n  = 1'b1;
          w_cnt_n = div;
          w_clk_n = 1'b0;
        end else begin
          // end of PH_LO: cycle complete
          w_act_n = 1'b0;
          w_clk_n = 1'b0;
          if (r_state == ST_RST) begin
            if (r_rcnt == RW'(RST_CYC - 1)) begin
              w_state_n = ST_HALT;
            end else begin
              w_rcnt_n = r_rcnt + RW'(1);
              w_act_n  = 1'b1;
              w_ph_n   = 1'b0;
              w_cnt_n  = div;
              w_clk_n  = 1'b1;
            end
          end else begin
            w_cycles_n = r_cycles + 16'd1;
            w_first_n  = 1'b0;
            if (r_state == ST_RUN &&
                !(r_pend | w_halt_e | w_brk_stop)) begin
              w_act_n = 1'b1;
              w_ph_n  = 1'b0;
              w_cnt_n = div;
              w_clk_n = 1'b1;
            end else begin
              w_state_n = ST_HALT;
              w_pend_n  = 1'b0;
            end
          end
        end
      end
    endcase
  end

  assign w_in_rst_n = (w_state_n == ST_RST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RST;
      r_act    <= 1'b0;
      r_ph     <= 1'b0;
      r_cnt    <= '0;
      r_rcnt   <= '0;
      r_cycles <= 16'd0;
      r_pend   <= 1'b0;
      r_first  <= 1'b0;
      r_clk    <= 1'b0;
      r_run_p  <= 1'b1;
      r_halt_p <= 1'b1;
      r_step_p <= 1'b1;
    end else begin
      r_state  <= w_state_n;
      r_act    <= w_act_n;
      r_ph     <= w_ph_n;
      r_cnt    <= w_cnt_n;
      r_rcnt   <= w_rcnt_n;
      r_cycles <= w_cycles_n;
      r_pend   <= w_pend_n;
      r_first  <= w_first_n;
      r_clk    <= w_clk_n;
      r_run_p  <= run_req;
      r_halt_p <= halt_req;
      r_step_p <= step_req;
    end
  end

  // status outputs follow the next state so they switch
  // on the same edge as the phase outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iclk    <= 1'b1;
      r_cpu_rst <= 1'b1;
      r_crstn   <= 1'b0;
      r_ctrlen  <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_iclk    <= ~w_clk_n;
      r_cpu_rst <= w_in_rst_n;
      r_crstn   <= ~w_in_rst_n;
      r_ctrlen  <= ~w_in_rst_n;
      r_running <= (w_state_n == ST_RUN) ||
                   (w_state_n == ST_STEP);
      r_halted  <= (w_state_n == ST_HALT);
    end
  end

  assign cpu_clk  = r_clk;
  assign cpu_iclk = r_iclk;
  assign cpu_rst  = r_cpu_rst;
  assign crstn    = r_crstn;
  assign ctrlen   = r_ctrlen;
  assign running  = r_running;
  assign halted   = r_halted;
  assign cycles   = r_cycles;

endmodule
